// File: rtl/alu_cmd_seq.sv
// Command sequencer for the 4-bit combinational alu: accepts load/op commands,
// iterates the op against a persistent accumulator and returns result and flags.
module alu_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [2:0]       lat_op;
  logic [WIDTH-1:0] lat_imm;
  logic [CNT_W-1:0] cnt;
  logic             flag_cout;
  logic             flag_zero;

  // Handshake outputs come straight from the state register, so neither
  // ready nor valid depends combinationally on the other side's strobe.
  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == RESP);
  assign res_data  = acc;
  assign res_cout  = flag_cout;
  assign res_zero  = flag_zero;
  assign alu_a     = acc;
  assign alu_b     = lat_imm;
  assign alu_op    = lat_op;

  // One ALU iteration per EXEC cycle; cnt counts the iterations still owed
  // after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      lat_op    <= '0;
      lat_imm   <= '0;
      cnt       <= '0;
      flag_cout <= 1'b0;
      flag_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_load) begin
              acc       <= cmd_imm;
              flag_cout <= 1'b0;
              flag_zero <= (cmd_imm == '0);
              state     <= RESP;
            end else begin
              lat_op  <= cmd_op;
              lat_imm <= cmd_imm;
              cnt     <= cmd_count;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          acc       <= alu_y;
          flag_cout <= alu_cout;
          flag_zero <= alu_zero;
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that drives the 4-bit combinational `alu` from the issuing side. It accepts operation commands over a valid/ready handshake and holds a 4-bit accumulator. It drives `alu` A/B/op each iteration, repeats the operation up to 4 times with writeback to the accumulator, and returns the result and flags over a second valid/ready handshake. It sits between the control path and the `alu` instance and owns all sequencing and state the ALU lacks.

## Interface
- `WIDTH`, 4, data width; must equal the `alu` operand width (4).
- `CNT_W`, 2, repeat-count width; an operation executes `cmd_count+1` times.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_load`  in  1  1 = load accumulator with `cmd_imm`; 0 = execute ALU op.
- `cmd_op`  in  3  ALU op code, same encoding as `alu` (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl, 111 shr).
- `cmd_imm`  in  WIDTH  B operand, or load value.
- `cmd_count`  in  CNT_W  repeat count minus one.
- `alu_a`  out  WIDTH  to `alu` A; always equals accumulator.
- `alu_b`  out  WIDTH  to `alu` B; latched `cmd_imm`.
- `alu_op`  out  3  to `alu` op; latched `cmd_op`.
- `alu_y`  in  WIDTH  from `alu` Y.
- `alu_cout`  in  1  from `alu` Cout.
- `alu_zero`  in  1  from `alu` Zero.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  WIDTH  accumulator value.
- `res_cout`  out  1  Cout of the last iteration; 0 for loads.
- `res_zero`  out  1  Zero of the last iteration; `(imm==0)` for loads.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`:
    - If `cmd_load`: acc←imm, cout←0, zero←(imm==0), go to RESP.
    - Else: latch op/imm, cnt←`cmd_count`, go to EXEC.
- **EXEC:**
  - `cmd_ready`=0; `alu_a/b/op` are held stable from registers.
  - Each cycle: acc←`alu_y`, flags←`alu_cout`/`alu_zero`.
  - If cnt==0 go to RESP, else cnt←cnt−1.
  - The ALU is purely combinational, so one iteration takes one cycle.
- **RESP:**
  - `res_valid`=1; `res_data`/`res_cout`/`res_zero` are stable.
  - On `res_ready`, go to IDLE.
  - No new command is accepted in RESP; commands never overlap.
- Arithmetic follows the `alu` exactly.
  - Sub Cout = bit 4 of the 5-bit A−B, i.e. 1 when a borrow occurs.
  - Logic, not and shift ops give Cout=0.
  - Shift-out bits are lost; no wrap-around.
- The accumulator persists across commands; only reset or a load changes it outside EXEC.

## Timing
- Reset values:
  - state IDLE, acc=0, latched op/imm=0, cnt=0.
  - `cmd_ready`=1 in the first cycle after reset.
  - `res_valid`=0, `res_data`=0, `res_cout`=0, `res_zero`=0.
  - `alu_a`=`alu_b`=0, `alu_op`=000.
- Latency, counted in cycles from the accept edge:
  - Load: `res_valid` is high 1 cycle after accept.
  - Op: `res_valid` is high `cmd_count+2` cycles after accept.
- `cmd_ready` and `res_valid` are decoded from registered state only; they have no combinational path from `cmd_valid` or `res_ready`.
- Backpressure: while `res_ready`=0, RESP holds indefinitely with outputs unchanged.
- `res_valid`&&`res_ready` on the same edge completes the transfer. `cmd_ready` rises the next cycle, so the best throughput is one command per `cmd_count+3` cycles.
- `cmd_valid` with `cmd_ready`=0 is ignored; the source must hold the command.
- Reset mid-EXEC or mid-RESP aborts the command:
  - the next cycle is IDLE with reset values;
  - the partial result is discarded and no `res_valid` pulse appears.
- `rst` takes priority over any simultaneous handshake.

## Test plan
- **Reset:** hold `rst` 2 cycles with `cmd_valid`=1 → after release `cmd_ready`=1, `res_valid`=0, `alu_a`=0, and no command was accepted during reset.
- **Load then add:** load imm 9 → `res_valid` 1 cycle later, `res_data`=9, `res_zero`=0. Then add imm 8, count 0 → `res_data`=1, `res_cout`=1, `res_zero`=0, `res_valid` 2 cycles after accept.
- **Repeated shift:** acc=1, op 110, count 3 → intermediate acc 2, 4, 8, 0 → `res_data`=0, `res_zero`=1, `res_cout`=0, `res_valid` 5 cycles after accept.
- **Sub with backpressure:** acc=3, sub imm 5 → `res_data`=4'hE, `res_cout`=1. Hold `res_ready`=0 for 3 cycles while driving `cmd_valid` → outputs stable, `cmd_ready`=0, and the command is accepted only after the result handshake.
- **Mid-op reset:** acc=1, op 110, count 3; assert `rst` on the 2nd EXEC cycle → the next cycle shows IDLE, acc=0, `res_valid` never asserts.
- **NOT/XOR chain:** load 4'hA, not (count 0) → 4'h5; xor imm 5 → 0 with `res_zero`=1, `res_cout`=0.
